// File: rtl/regression_pkg.sv
// Shared defaults, FSM state encoding and the fixed linear-model coefficients
// for the regression cost pipeline.
package regression_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_CNT_W  = 16;
    localparam int DEFAULT_ACC_W  = 72;

    localparam logic [31:0] THETA0 = 32'd10000;
    localparam logic [31:0] THETA1 = 32'd5000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_DIV,
        S_DONE
    } state_e;

    // Price predicted by the fixed model for a given size.
    function automatic logic [31:0] predict_price(input logic [31:0] size);
        return THETA0 + THETA1 * size;
    endfunction

endpackage

// File: rtl/regression_mse_if.sv
// Sample stream, run control and result bundle between the regression
// predictor side (master) and the MSE block (slave).
interface regression_mse_if
    import regression_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W,
    parameter int ACC_W  = DEFAULT_ACC_W
) ();

    logic              start;
    logic [CNT_W-1:0]  n_samples;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] predict;
    logic [DATA_W-1:0] label;
    logic              busy;
    logic              done;
    logic [ACC_W-1:0]  sse;
    logic [ACC_W-1:0]  mse;
    logic              overflow;
    logic              zero_n;

    modport master (
        output start, n_samples, in_valid, predict, label,
        input  in_ready, busy, done, sse, mse, overflow, zero_n
    );

    modport slave (
        input  start, n_samples, in_valid, predict, label,
        output in_ready, busy, done, sse, mse, overflow, zero_n
    );

endinterface

// File: rtl/regression_mse_divider.sv
// Restoring sequential divider: one quotient bit per cycle, ACC_W cycles per
// division, done pulses one cycle after the final bit; remainder is internal.
module seq_divider
    import regression_pkg::*;
#(
    parameter int ACC_W = DEFAULT_ACC_W,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [ACC_W-1:0] dividend_i,
    input  logic [CNT_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [ACC_W-1:0] quotient_o
);

    localparam int STEP_W = $clog2(ACC_W + 1);

    logic              busy_q;
    logic              done_q;
    logic [STEP_W-1:0] step_q;
    logic [ACC_W-1:0]  quo_q, quo_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  dsr_q;
    logic [CNT_W:0]    shifted;
    logic [CNT_W:0]    trial;

    // Partial remainder stays below the divisor, so the top bit of the trial
    // subtraction is a clean borrow flag.
    always_comb begin
        shifted = {rem_q, quo_q[ACC_W-1]};
        trial   = shifted - {1'b0, dsr_q};
        rem_d   = shifted[CNT_W-1:0];
        quo_d   = {quo_q[ACC_W-2:0], 1'b0};
        if (!trial[CNT_W]) begin
            rem_d = trial[CNT_W-1:0];
            quo_d = {quo_q[ACC_W-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            step_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (start_i && !busy_q) begin
                busy_q <= 1'b1;
                step_q <= STEP_W'(ACC_W);
            end else if (busy_q) begin
                step_q <= step_q - STEP_W'(1);
                if (step_q == STEP_W'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start_i && !busy_q) begin
            quo_q <= dividend_i;
            rem_q <= '0;
            dsr_q <= divisor_i;
        end else if (busy_q) begin
            quo_q <= quo_d;
            rem_q <= rem_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign quotient_o = quo_q;

endmodule

// File: rtl/regression_mse.sv
// Accumulates the sum of squared errors of (predict, label) pairs over a run
// and divides by the sample count to report the mean squared error.
module regression_mse
    import regression_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W,
    parameter int ACC_W  = DEFAULT_ACC_W
) (
    input  logic          clk,
    input  logic          rst,
    regression_mse_if.slave bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  n_q;
    logic [CNT_W-1:0]  count_q;
    logic              drain_q;
    logic [ACC_W-1:0]  acc_q;
    logic              ovf_q;
    logic [DATA_W-1:0] diff_p1_q;
    logic              vld_p1_q;
    logic [ACC_W-1:0]  sse_q, mse_q;
    logic              overflow_q, zero_n_q;

    logic              hs;
    logic              div_start;
    logic              div_busy;
    logic              div_done;
    logic [ACC_W-1:0]  div_quot;
    logic [ACC_W:0]    acc_sum;

    function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Returns {saturated, new accumulator}; clamps at all-ones on carry-out.
    function automatic logic [ACC_W:0] sat_accumulate(input logic [ACC_W-1:0]  acc,
                                                      input logic [DATA_W-1:0] d);
        logic [2*DATA_W-1:0] sq;
        logic [ACC_W:0]      sum;
        sq  = {{DATA_W{1'b0}}, d} * {{DATA_W{1'b0}}, d};
        sum = {1'b0, acc} + {{(ACC_W + 1 - 2*DATA_W){1'b0}}, sq};
        if (sum[ACC_W]) begin
            sum = {1'b1, {ACC_W{1'b1}}};
        end
        return sum;
    endfunction

    assign hs      = bus.in_valid && (state_q == S_ACCUM);
    assign acc_sum = sat_accumulate(acc_q, diff_p1_q);

    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = (bus.n_samples == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (hs && (count_q == n_q - CNT_W'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Divider is launched on the second drain cycle, when the
                // last square has landed in the accumulator.
                if (drain_q && !div_busy) begin
                    state_d   = S_DIV;
                    div_start = 1'b1;
                end
            end
            S_DIV: begin
                if (div_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            count_q    <= '0;
            drain_q    <= 1'b0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            vld_p1_q   <= 1'b0;
            sse_q      <= '0;
            mse_q      <= '0;
            overflow_q <= 1'b0;
            zero_n_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= (state_q == S_DRAIN) ? ~drain_q : 1'b0;
            vld_p1_q <= hs;
            if (state_q == S_IDLE && bus.start) begin
                n_q     <= bus.n_samples;
                count_q <= '0;
                acc_q   <= '0;
                ovf_q   <= 1'b0;
            end
            if (hs) begin
                count_q <= count_q + CNT_W'(1);
            end
            // stage 2: square and accumulate
            if (vld_p1_q) begin
                acc_q <= acc_sum[ACC_W-1:0];
                ovf_q <= ovf_q | acc_sum[ACC_W];
            end
            if (state_d == S_DONE) begin
                if (state_q == S_IDLE) begin
                    sse_q      <= '0;
                    mse_q      <= '0;
                    overflow_q <= 1'b0;
                    zero_n_q   <= 1'b1;
                end else begin
                    sse_q      <= acc_q;
                    mse_q      <= div_quot;
                    overflow_q <= ovf_q;
                    zero_n_q   <= 1'b0;
                end
            end
        end
    end

    // stage 1: absolute error
    always_ff @(posedge clk) begin
        if (hs) begin
            diff_p1_q <= abs_diff(bus.predict, bus.label);
        end
    end

    seq_divider #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .dividend_i (acc_q),
        .divisor_i  (n_q),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quot)
    );

    assign bus.in_ready = (state_q == S_ACCUM);
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.sse      = sse_q;
    assign bus.mse      = mse_q;
    assign bus.overflow = overflow_q;
    assign bus.zero_n   = zero_n_q;

endmodule

// File: tb/tb_regression_mse.sv
// Bench for regression_mse: event-level reference model checked every cycle,
// directed runs with literal expectations, and a 64-bit accumulator instance.
module tb_regression_mse;
    import regression_pkg::*;

    localparam int DW   = 32;
    localparam int CW   = 16;
    localparam int AW   = 72;
    localparam int AW64 = 64;
    localparam logic [127:0] MAX_ACC = (128'd1 << AW) - 128'd1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regression_mse_if #(.DATA_W(DW), .CNT_W(CW), .ACC_W(AW))   if0();
    regression_mse_if #(.DATA_W(DW), .CNT_W(CW), .ACC_W(AW64)) if1();

    regression_mse #(.DATA_W(DW), .CNT_W(CW), .ACC_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    regression_mse #(.DATA_W(DW), .CNT_W(CW), .ACC_W(AW64)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;
    int m_done_edge = -1;
    int m_left = 0;
    bit chk_en = 0;
    bit m_ready, m_busy, m_done, m_ovf, m_zero;
    logic [127:0] m_sum = '0, m_n = '0, m_sse = '0, m_mse = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ready = 0; m_busy = 0; m_done = 0; m_ovf = 0; m_zero = 0;
        m_sum = '0; m_n = '0; m_sse = '0; m_mse = '0;
        m_left = 0; m_done_edge = -1;
    endtask

    // One clock edge; the model advances from what was presented before it.
    task automatic step();
        bit hs, st;
        logic [15:0]  nsmp;
        logic [127:0] d;
        hs   = (if0.in_valid === 1'b1) && m_ready && !rst;
        st   = (if0.start === 1'b1) && !m_busy && !rst;
        nsmp = if0.n_samples;
        d    = (if0.predict > if0.label) ? 128'(if0.predict - if0.label)
                                         : 128'(if0.label - if0.predict);
        @(posedge clk);
        edge_n++;
        if (m_done) begin
            m_done = 0;
            m_busy = 0;
        end
        if (st && nsmp == 16'd0) begin
            m_busy = 1; m_done = 1; m_sse = '0; m_mse = '0; m_ovf = 0; m_zero = 1;
        end else if (st) begin
            m_busy = 1; m_ready = 1; m_left = int'(nsmp); m_n = 128'(nsmp); m_sum = '0;
        end
        if (hs) begin
            m_sum = m_sum + d * d;
            m_left--;
            if (m_left == 0) begin
                m_ready = 0;
                m_done_edge = edge_n + AW + 3;
            end
        end
        if (edge_n == m_done_edge) begin
            m_done = 1;
            m_ovf  = (m_sum > MAX_ACC);
            m_sse  = m_ovf ? MAX_ACC : m_sum;
            m_mse  = m_sse / m_n;
            m_zero = 0;
            m_done_edge = -1;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 128'(if0.in_ready), 128'(m_ready));
            chk("busy",     128'(if0.busy),     128'(m_busy));
            chk("done",     128'(if0.done),     128'(m_done));
            chk("sse",      128'(if0.sse),      m_sse);
            chk("mse",      128'(if0.mse),      m_mse);
            chk("overflow", 128'(if0.overflow), 128'(m_ovf));
            chk("zero_n",   128'(if0.zero_n),   128'(m_zero));
        end
    end

    task automatic start_run(input logic [15:0] n);
        if0.n_samples = n;
        if0.start     = 1'b1;
        step();
        if0.start     = 1'b0;
        if0.n_samples = 16'd7;
    endtask

    task automatic send(input logic [31:0] p, input logic [31:0] l, input bit poke);
        bit got;
        got = 0;
        if0.predict  = p;
        if0.label    = l;
        if0.in_valid = 1'b1;
        if (poke) begin
            if0.start     = 1'b1;
            if0.n_samples = 16'd9;
        end
        for (int k = 0; k < 50 && !got; k++) begin
            got = (if0.in_ready === 1'b1);
            step();
            if0.start = 1'b0;
        end
        if0.in_valid = 1'b0;
        if (!got) chk("accept_timeout", 128'(got), 128'd1);
    endtask

    task automatic wait_done(input bit poke, output int lat);
        lat = 0;
        if (poke) if0.in_valid = 1'b1;
        while (if0.done !== 1'b1 && lat < AW + 20) begin
            if (poke && lat == 10) begin
                if0.start     = 1'b1;
                if0.n_samples = 16'd2;
            end
            step();
            lat++;
            if0.start = 1'b0;
        end
        if0.in_valid = 1'b0;
    endtask

    task automatic run3(input int gmax, input bit mix, input bit poke, input string tag);
        logic [31:0] vp[3], vl[3];
        int lat;
        vp[0] = predict_price(32'd2); vl[0] = 32'd21000;
        vp[1] = predict_price(32'd1); vl[1] = 32'd15000;
        vp[2] = predict_price(32'd4); vl[2] = 32'd27000;
        start_run(16'd3);
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(gmax, 0)) step();
            if (mix) send(vl[i], vp[i], poke && i == 1);
            else     send(vp[i], vl[i], poke && i == 1);
        end
        chk({tag, "_ready_after_last"}, 128'(if0.in_ready), 128'd0);
        wait_done(poke, lat);
        chk({tag, "_latency"}, 128'(lat), 128'(AW + 3));
        chk({tag, "_sse_lit"}, 128'(if0.sse), 128'd10000000);
        chk({tag, "_mse_lit"}, 128'(if0.mse), 128'd3333333);
        step();
    endtask

    initial begin
        int lat;
        bit seen;
        bit got;
        model_reset();
        if0.start = 0; if0.n_samples = '0; if0.in_valid = 0; if0.predict = '0; if0.label = '0;
        if1.start = 0; if1.n_samples = '0; if1.in_valid = 0; if1.predict = '0; if1.label = '0;
        rst = 1'b1;
        step(); step(); step();
        chk_en = 1;
        chk("reset_in_ready", 128'(if0.in_ready), 128'd0);
        chk("reset_sse", 128'(if0.sse), 128'd0);
        rst = 1'b0;
        step(); step();

        run3(0, 0, 0, "plain");
        chk("model_sse_pin", m_sse, 128'd10000000);
        chk("model_mse_pin", m_mse, 128'd3333333);
        run3(5, 1, 0, "gaps");
        run3(3, 0, 1, "poke");

        // zero-length run
        start_run(16'd0);
        chk("zero_done", 128'(if0.done), 128'd1);
        chk("zero_flag", 128'(if0.zero_n), 128'd1);
        chk("zero_sse", 128'(if0.sse), 128'd0);
        chk("zero_mse", 128'(if0.mse), 128'd0);
        step();
        chk("zero_done_clear", 128'(if0.done), 128'd0);

        // single sample: mse equals sse
        start_run(16'd1);
        send(32'd10000, 32'd0, 0);
        wait_done(0, lat);
        chk("n1_sse", 128'(if0.sse), 128'd100000000);
        chk("n1_mse", 128'(if0.mse), 128'd100000000);
        chk("n1_zero_n", 128'(if0.zero_n), 128'd0);
        step();

        // asynchronous reset in the middle of the division
        start_run(16'd1);
        send(32'd30000, 32'd0, 0);
        repeat (10) step();
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_sse", 128'(if0.sse), 128'd0);
        chk("async_mse", 128'(if0.mse), 128'd0);
        chk("async_busy", 128'(if0.busy), 128'd0);
        step(); step();
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < AW + 10; k++) begin
            step();
            if (if0.done === 1'b1) seen = 1;
        end
        chk("no_done_after_reset", 128'(seen), 128'd0);

        // 64-bit accumulator saturation
        if1.n_samples = 16'd2;
        if1.start = 1'b1;
        step();
        if1.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if1.predict = 32'hFFFF_FFFF;
            if1.label = 32'd0;
            if1.in_valid = 1'b1;
            got = 0;
            for (int k = 0; k < 50 && !got; k++) begin
                got = (if1.in_ready === 1'b1);
                step();
            end
            if1.in_valid = 1'b0;
            if (!got) chk("ovf_accept_timeout", 128'(got), 128'd1);
        end
        lat = 0;
        while (if1.done !== 1'b1 && lat < AW64 + 20) begin
            step();
            lat++;
        end
        chk("ovf_latency", 128'(lat), 128'(AW64 + 3));
        chk("ovf_flag", 128'(if1.overflow), 128'd1);
        chk("ovf_sse", 128'(if1.sse), 128'hFFFF_FFFF_FFFF_FFFF);
        chk("ovf_mse", 128'(if1.mse), 128'h7FFF_FFFF_FFFF_FFFF);
        step();

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
